// File: rtl/mux_rr_reg_if.sv
// Handshake bundle for mux_rr_reg: N input channels merged onto one registered output.
interface mux_rr_reg_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_src;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/mux_rr_reg.sv
// N-input registered mux with valid/ready handshakes; fixed-select or round-robin grant.
module mux_rr_reg #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    mux_rr_reg_if.slave      bus
);
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant_c;
    logic             grant_ok_c;
    logic             can_load_c;
    logic             xfer_c;
    logic [WIDTH-1:0] data_c;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [SEL_W-1:0] out_src_q;

    assign can_load_c = !out_valid_q || bus.out_ready;
    assign xfer_c     = !rst && grant_ok_c && can_load_c;

    // Grant selection; sel values >= N never match a channel and so never grant.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        grant_c    = sel;
        grant_ok_c = 1'b0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (32'(sel) == i) grant_ok_c = bus.in_valid[i];
            end
        end else begin
            grant_c = '0;
            for (int unsigned k = 0; k < N; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= N) idx = idx - N;
                if (!grant_ok_c && bus.in_valid[idx]) begin
                    grant_ok_c = 1'b1;
                    grant_c    = SEL_W'(idx);
                end
            end
        end
    end

    always_comb begin
        data_c       = '0;
        bus.in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(grant_c) == i) begin
                data_c          = bus.in_data[i*WIDTH +: WIDTH];
                bus.in_ready[i] = xfer_c;
            end
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_ptr      <= '0;
        end else if (xfer_c) begin
            out_data_q  <= data_c;
            out_valid_q <= 1'b1;
            out_src_q   <= grant_c;
            if (mode) begin
                rr_ptr <= (32'(grant_c) == N - 1) ? '0 : grant_c + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the combinational 2:1 32-bit mux used in the MIPS datapath.
- Adds a selectable arbitration mode, fixed-select or round-robin, and a one-stage output register.
- Intended for merging multiple producers, such as writeback sources or memory request ports, onto one registered bus.

Parameters:
- WIDTH, 32: data width of each channel and of the output.
- N, 4: number of input channels (2..16).
- SEL_W, 2: select/index width; must equal clog2(N), minimum 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready (combinational).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_src  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset values:
  - On a clk edge with rst=1: out_data=0, out_valid=0, out_src=0, internal pointer rr_ptr=0.
  - While rst=1, in_ready is forced to all zeros.
- Slot free condition: can_load = !out_valid || out_ready. This allows full throughput of 1 transfer/cycle.
- Grant, mode=0:
  - grant=sel; grant_ok = (sel < N) && in_valid[sel].
  - sel >= N: no grant, all in_ready=0.
- Grant, mode=1:
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1.
  - grant_ok = |in_valid.
- in_ready[i] = !rst && grant_ok && can_load && (i == grant). At most one bit is set.
- Transfer: occurs on channel grant at the clk edge where in_valid[grant] && in_ready[grant]. On that edge:
  - out_data <= channel data
  - out_src <= grant
  - out_valid <= 1
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their values.
- Stall: while out_valid=1 and out_ready=0, out_data, out_src and out_valid are held stable and all in_ready are 0.
- Latency: input accepted at edge k is visible on the output from edge k onward (1-cycle register latency).
- rr_ptr update:
  - Only on a transfer while mode=1: rr_ptr <= (grant == N-1) ? 0 : grant+1.
  - mode=0 transfers leave rr_ptr unchanged.
- Mode or sel changes take effect combinationally in the same cycle. An already-registered output is unaffected.
- Reset mid-operation:
  - A pending output is dropped (out_valid=0 after the edge).
  - No transfer occurs on the reset edge, even if in_valid is high.
- Combinational paths: in_ready depends on out_ready, in_valid, mode, sel, rst. There is no path from in_data to any output except through the register.

Test Plan:
1. Reset:
   - Stimulus: hold rst=1 for 2 cycles with all in_valid=1.
   - Required: out_valid=0, out_data=0, out_src=0, in_ready=0 throughout; after release, the first grant in mode 1 is channel 0.
2. Fixed select:
   - Stimulus: mode=0, ch0=0xAAAA_AAAA, ch1=0x5555_5555, both valid, out_ready=1, sel=0, then sel=1.
   - Required: out_data=0xAAAA_AAAA with out_src=0, then 0x5555_5555 with out_src=1, each one cycle after acceptance.
3. Backpressure:
   - Stimulus: mode=0, sel=2, ch2=0x1234_5678 valid, out_ready=0 for 3 cycles.
   - Required: out_data held at 0x1234_5678 with out_valid=1 and in_ready=0 during the stall; then 1 output beat when out_ready rises, and the next beat follows immediately.
4. Round-robin fairness and wrap:
   - Stimulus: N=4, mode=1, all four channels continuously valid carrying data i+0x10, out_ready=1.
   - Required: out_src sequence 0,1,2,3,0,1 at 1 beat/cycle.
   - Stimulus: only ch1 and ch3 valid.
   - Required: out_src alternates 1,3,1,3.
5. Invalid select:
   - Stimulus: N=3, SEL_W=2, mode=0, sel=3, all channels valid.
   - Required: in_ready=000 and out_valid stays 0.
6. Reset mid-stall:
   - Stimulus: out_valid=1 with out_ready=0, assert rst for 1 cycle.
   - Required: out_valid=0 and rr_ptr=0 after the edge; no data is lost from inputs, since in_ready was 0.
